pkt_dmux: RTL

PKT_DMUX -- requirements
Module: pkt_dmux

---
 rtl/pkt_dmux.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pkt_dmux.sv
// Packet demultiplexer: classifies each packet by the EtherType in its head
// flit, steers it to one of four sinks (conf, DMA, DRA, UART), or drops it
// when the chosen sink is almost-full. Flags framing errors and counts drops
// and framing errors. One cycle of latency.
module pkt_dmux #(
    parameter logic [15:0] P_CONF_ETYPE = 16'h9005,
    parameter logic [15:0] P_UART_ETYPE = 16'h9006
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_data_valid,
    input  logic [133:0] i_data,
    input  logic         i_dra_sel,
    input  logic         i_dma_alf,
    input  logic         i_dra_alf,
    input  logic         i_uart_alf,
    output logic [133:0] o_data,
    output logic         o_valid_conf,
    output logic         o_valid_dma,
    output logic         o_valid_dra,
    output logic         o_valid_uart,
    output logic [15:0]  o_cnt_drop,
    output logic [15:0]  o_cnt_err,
    output logic         o_err
);

    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;
    typedef enum logic [1:0] {DST_CONF, DST_DMA, DST_DRA, DST_UART} dest_t;

    localparam logic [1:0] TAG_TAIL   = 2'b10;
    localparam logic [1:0] TAG_SINGLE = 2'b11;

    state_t      state, state_next;
    dest_t       dest, dest_next, head_dest, flit_dest;
    logic [1:0]  tag;
    logic [15:0] etype;
    logic        is_start;
    logic        head_drop;
    logic        fwd;
    logic        drop_pkt;
    logic        frame_err;

    assign tag      = i_data[133:132];
    assign etype    = i_data[127:112];
    // Head and single-flit tags both have bit 0 set: they open a packet.
    assign is_start = tag[0];

    // Classify the current flit as if it were a head, and decide whether its sink is full.
    always_comb begin
        if (etype == P_CONF_ETYPE)
            head_dest = DST_CONF;
        else if (etype == P_UART_ETYPE)
            head_dest = DST_UART;
        else if (i_dra_sel)
            head_dest = DST_DRA;
        else
            head_dest = DST_DMA;

        case (head_dest)
            DST_DMA:  head_drop = i_dma_alf;
            DST_DRA:  head_drop = i_dra_alf;
            DST_UART: head_drop = i_uart_alf;
            default:  head_drop = 1'b0;
        endcase
    end

    // Packet state and latched destination.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            dest  <= DST_CONF;
        end else begin
            state <= state_next;
            dest  <= dest_next;
        end
    end

    // Next packet state; any start flit restarts classification regardless of state.
    always_comb begin
        state_next = state;
        dest_next  = dest;
        if (i_data_valid) begin
            if (is_start) begin
                dest_next = head_dest;
                if (tag == TAG_SINGLE)
                    state_next = IDLE;
                else
                    state_next = head_drop ? DROP : FWD;
            end else if (state != IDLE && tag == TAG_TAIL) begin
                state_next = IDLE;
            end
        end
    end

    // Per-flit decision: forward, drop, or framing error.
    always_comb begin
        fwd       = 1'b0;
        drop_pkt  = 1'b0;
        frame_err = 1'b0;
        flit_dest = dest;
        if (i_data_valid) begin
            if (is_start) begin
                flit_dest = head_dest;
                fwd       = !head_drop;
                drop_pkt  = head_drop;
                frame_err = (state != IDLE);
            end else begin
                fwd       = (state == FWD);
                frame_err = (state == IDLE);
            end
        end
    end

    // Registered outputs and counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_data       <= '0;
            o_valid_conf <= 1'b0;
            o_valid_dma  <= 1'b0;
            o_valid_dra  <= 1'b0;
            o_valid_uart <= 1'b0;
            o_err        <= 1'b0;
            o_cnt_drop   <= '0;
            o_cnt_err    <= '0;
        end else begin
            if (i_data_valid)
                o_data <= i_data;
            o_valid_conf <= fwd && (flit_dest == DST_CONF);
            o_valid_dma  <= fwd && (flit_dest == DST_DMA);
            o_valid_dra  <= fwd && (flit_dest == DST_DRA);
            o_valid_uart <= fwd && (flit_dest == DST_UART);
            o_err        <= frame_err;
            if (drop_pkt)
                o_cnt_drop <= o_cnt_drop + 16'd1;
            if (frame_err)
                o_cnt_err <= o_cnt_err + 16'd1;
        end
    end

endmodule
